// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared defaults and FSM state encoding for the FIFO write arbiter
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

   // Default FIFO data width
   localparam int DW_DEF = 3;
   // Default grant-counter width
   localparam int CW_DEF = 8;

   // Write-side FSM: IDLE samples requests, WRITE is the settle cycle
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } fifo_state_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin pick. A lone requester wins outright; on a
//            tie the requester that was not granted last wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
   input  logic req0,
   input  logic req1,
   input  logic last,     // index of the requester granted most recently
   output logic winner,   // 0 = requester 0, 1 = requester 1
   output logic valid
);

   // Requester 1 wins when alone, or on a tie when requester 0 went last
   always_comb begin
      valid  = req0 | req1;
      winner = req1 & ~(req0 & last);
   end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arb
// Purpose  : Arbitrates two write requesters onto a single FIFO write port.
//            One write at most every two cycles so full settles between
//            writes. Keeps saturating per-requester grant counts.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arb
   import fifo_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst,     // asynchronous, active-low
   input  logic          req0,
   input  logic [DW-1:0] dat0,
   input  logic          req1,
   input  logic [DW-1:0] dat1,
   output logic          gnt0,
   output logic          gnt1,
   input  logic          full,
   output logic          wr,
   output logic [DW-1:0] datin,
   input  logic          clr,
   output logic [CW-1:0] cnt0,
   output logic [CW-1:0] cnt1
);

   localparam logic [CW-1:0] c_CNT_ONE = CW'(1);
   localparam logic [CW-1:0] c_CNT_MAX = '1;

   fifo_state_t   r_state;
   fifo_state_t   w_state_nxt;
   logic          r_wr,    w_wr_nxt;
   logic          r_gnt0,  w_gnt0_nxt;
   logic          r_gnt1,  w_gnt1_nxt;
   logic [DW-1:0] r_datin, w_datin_nxt;
   logic          r_last,  w_last_nxt;
   logic [CW-1:0] r_cnt0;
   logic [CW-1:0] r_cnt1;
   logic          w_winner;
   logic          w_valid;

   rr_arb2 u_rr_arb2 (
      .req0   (req0),
      .req1   (req1),
      .last   (r_last),
      .winner (w_winner),
      .valid  (w_valid)
   );

   // Next-state and next-output decode; full is only looked at in IDLE
   always_comb begin
      w_state_nxt = r_state;
      w_wr_nxt    = 1'b0;
      w_gnt0_nxt  = 1'b0;
      w_gnt1_nxt  = 1'b0;
      w_datin_nxt = r_datin;
      w_last_nxt  = r_last;
      case (r_state)
         IDLE: begin
            if (!full && w_valid) begin
               w_state_nxt = WRITE;
               w_wr_nxt    = 1'b1;
               w_gnt0_nxt  = ~w_winner;
               w_gnt1_nxt  = w_winner;
               w_datin_nxt = w_winner ? dat1 : dat0;
               w_last_nxt  = w_winner;
            end
         end
         WRITE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset leaves requester 0 first on a tie
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_wr    <= 1'b0;
         r_gnt0  <= 1'b0;
         r_gnt1  <= 1'b0;
         r_datin <= '0;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_wr    <= w_wr_nxt;
         r_gnt0  <= w_gnt0_nxt;
         r_gnt1  <= w_gnt1_nxt;
         r_datin <= w_datin_nxt;
         r_last  <= w_last_nxt;
      end
   end

   // Saturating grant counters, counted on the edge that raises the grant;
   // clr wins over a coincident increment
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else if (clr) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else begin
         if (w_gnt0_nxt && (r_cnt0 != c_CNT_MAX)) r_cnt0 <= r_cnt0 + c_CNT_ONE;
         if (w_gnt1_nxt && (r_cnt1 != c_CNT_MAX)) r_cnt1 <= r_cnt1 + c_CNT_ONE;
      end
   end

   assign wr    = r_wr;
   assign gnt0  = r_gnt0;
   assign gnt1  = r_gnt1;
   assign datin = r_datin;
   assign cnt0  = r_cnt0;
   assign cnt1  = r_cnt1;

endmodule : fifo_wr_arb
`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arb
// Purpose  : Directed scoreboard bench for fifo_wr_arb
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arb;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [2:0] dat0 = '0, dat1 = '0;
   logic       full = 1'b0, clr = 1'b0;
   logic       gnt0, gnt1, wr;
   logic [2:0] datin;
   logic [7:0] cnt0, cnt1;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      int         cyc;
      logic       id;
      logic [2:0] dat;
      logic [7:0] c0;
      logic [7:0] c1;
   } exp_t;
   exp_t q[$];

   fifo_wr_arb #(.DW(3), .CW(8)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .dat0(dat0), .req1(req1), .dat1(dat1),
      .gnt0(gnt0), .gnt1(gnt1), .full(full), .wr(wr), .datin(datin),
      .clr(clr), .cnt0(cnt0), .cnt1(cnt1)
   );

   always #5 clk = ~clk;

   // Cycle counter: value N after the Nth rising edge
   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int c, input logic id, input logic [2:0] d,
                       input int c0, input int c1);
      exp_t e;
      e.cyc = c; e.id = id; e.dat = d; e.c0 = c0[7:0]; e.c1 = c1[7:0];
      q.push_back(e);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every write beat is popped and compared against the scoreboard
   initial forever begin
      @(negedge clk);
      if (rst) begin
         if (gnt0 || gnt1) begin
            n_tests++;
            if ((gnt0 && gnt1) || !wr) begin
               n_fail++;
               $display("FAIL gnt_excl: gnt0=%0b gnt1=%0b wr=%0b (cycle %0d)", gnt0, gnt1, wr, cyc);
            end
         end
         if (wr) begin
            n_tests++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_wr: wr=1 gnt0=%0b gnt1=%0b datin=%0d, expected no write (cycle %0d)",
                        gnt0, gnt1, datin, cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (cyc != e.cyc || gnt0 != !e.id || gnt1 != e.id || datin != e.dat ||
                   cnt0 != e.c0 || cnt1 != e.c1) begin
                  n_fail++;
                  $display("FAIL wr_beat: got cyc=%0d gnt0=%0b gnt1=%0b datin=%0d cnt0=%0d cnt1=%0d, expected cyc=%0d id=%0d datin=%0d cnt0=%0d cnt1=%0d",
                           cyc, gnt0, gnt1, datin, cnt0, cnt1, e.cyc, e.id, e.dat, e.c0, e.c1);
               end
            end
         end
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_wr"}, wr, 0);
      chk({tag, "_gnt0"}, gnt0, 0);
      chk({tag, "_gnt1"}, gnt1, 0);
      chk({tag, "_datin"}, datin, 0);
      chk({tag, "_cnt0"}, cnt0, 0);
      chk({tag, "_cnt1"}, cnt1, 0);
   endtask

   initial begin
      int c;
      // Reset state
      wait_cycles(3);
      chk_zero("reset");
      rst = 1'b1;

      // Single requester 0 held: grants at +1, +3, +5
      wait_cycles(1);
      c = cyc; req0 = 1'b1; dat0 = 3'd2;
      push(c + 1, 1'b0, 3'd2, 1, 0);
      push(c + 3, 1'b0, 3'd2, 2, 0);
      push(c + 5, 1'b0, 3'd2, 3, 0);
      wait_cycles(5);
      req0 = 1'b0;
      wait_cycles(3);
      chk("single_drained", q.size(), 0);

      // Mid-run asynchronous reset clears everything, including counts
      #2 rst = 1'b0;
      #1 chk_zero("async_rst");
      wait_cycles(1);
      rst = 1'b1;

      // Both requesting: 0,1,0,1 with 6,4,6,4
      wait_cycles(1);
      c = cyc; req0 = 1'b1; dat0 = 3'd6; req1 = 1'b1; dat1 = 3'd4;
      push(c + 1, 1'b0, 3'd6, 1, 0);
      push(c + 3, 1'b1, 3'd4, 1, 1);
      push(c + 5, 1'b0, 3'd6, 2, 1);
      push(c + 7, 1'b1, 3'd4, 2, 2);
      wait_cycles(7);
      req0 = 1'b0; req1 = 1'b0;
      wait_cycles(3);
      chk("tie_drained", q.size(), 0);

      // full blocks requester 1 for 5 cycles, then releases the write
      full = 1'b1; req1 = 1'b1; dat1 = 3'd7;
      for (int i = 0; i < 5; i++) begin
         wait_cycles(1);
         chk("full_blocks_wr", wr, 0);
      end
      c = cyc; full = 1'b0;
      push(c + 1, 1'b1, 3'd7, 2, 3);
      wait_cycles(1);
      req1 = 1'b0; full = 1'b1;   // full rising in WRITE must not disturb the beat
      wait_cycles(2);
      full = 1'b0;
      chk("full_drained", q.size(), 0);

      // Reset during the WRITE cycle of a requester-1 grant
      c = cyc; req1 = 1'b1; dat1 = 3'd5;
      push(c + 1, 1'b1, 3'd5, 2, 4);
      wait_cycles(1);
      @(negedge clk);
      #1 rst = 1'b0; req1 = 1'b0;
      #1 chk_zero("rst_in_write");
      wait_cycles(2);
      rst = 1'b1;
      c = cyc; req0 = 1'b1; dat0 = 3'd1; req1 = 1'b1; dat1 = 3'd3;
      push(c + 1, 1'b0, 3'd1, 1, 0);
      wait_cycles(1);
      req0 = 1'b0; req1 = 1'b0;
      wait_cycles(2);
      chk("post_rst_drained", q.size(), 0);

      // 260 grants to requester 0: count saturates at 255
      c = cyc; req0 = 1'b1; dat0 = 3'd3;
      for (int k = 0; k < 260; k++)
         push(c + 1 + 2 * k, 1'b0, 3'd3, (2 + k > 255) ? 255 : 2 + k, 0);
      wait_cycles(519);
      req0 = 1'b0;
      wait_cycles(2);
      chk("sat_cnt0", cnt0, 255);
      chk("sat_drained", q.size(), 0);

      // Synchronous clear
      clr = 1'b1;
      wait_cycles(1);
      clr = 1'b0;
      chk("clr_cnt0", cnt0, 0);
      chk("clr_cnt1", cnt1, 0);

      wait_cycles(2);
      chk("final_queue_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule : tb_fifo_wr_arb
`default_nettype wire
